load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port. Sits between the MEM pipeline stage and the word-addressed data memory, which reads combinationally and writes on the clock edge with per-lane byte enables. It converts RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word transactions with the correct byte enables and lane-shifted data. Misaligned accesses that cross a word boundary are split into two transactions, and load data is merged and sign/zero-extended.

## Interface
- XLEN, from defs.vh (32): data/address width; lane math fixed at 4 bytes/word
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 size/sign code
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  with resp_valid: illegal funct3, no memory access made
- mem_valid  out  1  memory transaction strobe
- mem_we  out  1  memory write enable
- mem_addr  out  XLEN  word address; bits [1:0] always 0
- mem_wdata  out  XLEN  lane-positioned write data
- mem_byte_enable  out  4  per-lane enable
- mem_rdata  in  XLEN  combinational read word

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: on accept, latch we/funct3/addr/wdata.
  - Legal funct3 -> ACC0.
  - Illegal funct3 -> RESP with err=1. Illegal = load 011/110/111; store any other than 000/001/010.
- Size s: 1/2/4 bytes for funct3[1:0] = 00/01/10. Offset o = addr[1:0]. Split = (o + s > 4).
- ACC0:
  - mem_valid=1, mem_we=we, mem_addr = {addr[XLEN-1:2], 2'b00}.
  - Byte enables: lanes o .. min(o+s,4)-1. mem_wdata = wdata << 8·o (truncated).
  - Loads capture mem_rdata into low word buffer.
  - Next state: ACC1 if split, else RESP.
- ACC1:
  - mem_addr = ({addr[XLEN-1:2]} + 1) << 2. Word index wraps modulo 2^(XLEN-2), so 0xFFFFFFFE crosses to word 0.
  - Byte enables: lanes 0 .. o+s-5. mem_wdata = wdata >> 8·(4-o).
  - Loads capture into high word buffer. Next state: RESP.
- RESP: resp_valid=1 for one cycle, then -> IDLE.
  - Load result: take {hi, lo} >> 8·o, keep s bytes. Sign-extend for funct3[2]=0, zero-extend for funct3[2]=1.
- Reads also drive byte enables; memory ignores them.
- Outside ACC0/ACC1, memory outputs are held at 0: mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable.

## Timing
- Reset value of every output is 0, except req_ready=1. State resets to IDLE and buffers clear.
- Acceptance edge E0. Aligned access: ACC0 in cycle E0+1, resp_valid in E0+2. Split access: resp_valid in E0+3. Error: resp_valid in E0+1.
- Store data is written at the end of each ACCx cycle.
- req_ready=0 from the accept edge until RESP has completed. Back-to-back throughput: one request per 3 cycles aligned, 4 split.
- Inputs other than req_* are ignored outside IDLE. A req_valid held high during busy is not double-accepted.
- Reset mid-operation: return to IDLE next edge with no resp_valid.
  - A split store reset after ACC0 leaves the first half written and the second half unissued. This is expected; the pipeline flushes on reset.

## Structure
- Shared package mem_pkg: funct3 encodings (F3_B/H/W/BU/HU), lsu_state_t enum, BYTES_PER_WORD=4.
- Sub-module lsu_align: combinational.
  - Inputs: offset, size, half-select.
  - Outputs: byte_enable, write shift amount, split flag.
  - Instantiated once; shared by ACC0/ACC1.
- Load extraction/extension lives in the top module.

## Test plan
- SW 0x100, data 0xDEADBEEF:
  - One mem_valid cycle, be=1111, addr 0x100.
  - resp_valid at E0+2, rdata=0.
- After that store, LB 0x103 -> resp_rdata 0xFFFFFFDE. LBU 0x103 -> 0x000000DE. LH 0x102 -> 0xFFFFDEAD.
- SH 0x101, data 0x0000CAFE: be=0110, mem_wdata=0x00CAFE00. Reading word 0x100 afterwards gives 0xDECAFEEF.
- Split SW 0x0FE, data 0x11223344:
  - ACC0: addr 0x0FC, be=1100, wdata 0x33440000.
  - ACC1: addr 0x100, be=0011, wdata 0x00001122.
  - Follow-up LW 0x0FE returns 0x11223344 at E0+3.
- Load with funct3=011: resp_valid+resp_err at E0+1, mem_valid never asserted. Store with funct3=100 behaves the same.
- Assert rst during ACC1 of a split LW: no resp_valid, req_ready=1 and all mem_* = 0 on the next cycle. A subsequent aligned LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: RV32 funct3 size codes,
// load/store FSM states and word geometry.
package mem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } lsu_state_t;

    // Stores have no unsigned variants; loads accept the five RV32 codes.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane math for one half of a (possibly split) access: byte enables,
// write-data shift in bits, and whether the access spills into the next word.
module lsu_align (
    input  logic [1:0] offset_i,
    input  logic [1:0] size_i,
    input  logic       hi_i,
    output logic [3:0] byte_enable_o,
    output logic [5:0] shamt_o,
    output logic       split_o
);

    logic [3:0] size_mask;
    logic [7:0] lanes;

    always_comb begin
        case (size_i)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        // Lanes 7..4 of the shifted mask are the spill-over into the next word.
        lanes         = {4'b0000, size_mask} << offset_i;
        byte_enable_o = hi_i ? lanes[7:4] : lanes[3:0];
        shamt_o       = hi_i ? (6'd32 - {1'b0, offset_i, 3'b000})
                             : {1'b0, offset_i, 3'b000};
        split_o       = |lanes[7:4];
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns RV32 byte/half/word loads and stores into one or
// two aligned word transactions and returns merged, extended load data.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_byte_enable,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] hi_q;

    logic            req_ready_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            mem_valid_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [3:0]      mem_be_q;

    logic              is_idle;
    logic              accept;
    logic [1:0]        al_offset;
    logic [1:0]        al_size;
    logic              al_hi;
    logic [3:0]        al_be;
    logic [5:0]        al_shamt;
    logic              al_split;
    logic [XLEN-3:0]   next_word;
    logic [2*XLEN-1:0] pair_d;
    logic [XLEN-1:0]   word_d;
    logic [XLEN-1:0]   rdata_d;

    // Outputs are registered one state ahead, so in IDLE the aligner looks at the
    // incoming request (first half) and in ACC0 at the latched one (second half).
    always_comb begin
        is_idle   = (state_q == IDLE);
        accept    = req_valid && req_ready_q;
        al_offset = is_idle ? req_addr[1:0]   : addr_q[1:0];
        al_size   = is_idle ? req_funct3[1:0] : f3_q[1:0];
        al_hi     = !is_idle;
    end

    lsu_align u_align (
        .offset_i      (al_offset),
        .size_i        (al_size),
        .hi_i          (al_hi),
        .byte_enable_o (al_be),
        .shamt_o       (al_shamt),
        .split_o       (al_split)
    );

    assign next_word = addr_q[XLEN-1:2] + {{(XLEN-3){1'b0}}, 1'b1};

    // Load data is formed from the word arriving this cycle plus the buffered half.
    always_comb begin
        pair_d = (state_q == ACC1) ? {mem_rdata, lo_q} : {hi_q, mem_rdata};
        word_d = XLEN'(pair_d >> {addr_q[1:0], 3'b000});
        case (f3_q[1:0])
            2'b00:   rdata_d = {{(XLEN-8){word_d[7] & ~f3_q[2]}}, word_d[7:0]};
            2'b01:   rdata_d = {{(XLEN-16){word_d[15] & ~f3_q[2]}}, word_d[15:0]};
            default: rdata_d = word_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (f3_legal(req_we, req_funct3)) begin
                            state_q     <= ACC0;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wdata_q <= req_wdata << al_shamt;
                            mem_be_q    <= al_be;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                ACC0: begin
                    if (!we_q) lo_q <= mem_rdata;
                    if (al_split) begin
                        state_q     <= ACC1;
                        mem_addr_q  <= {next_word, 2'b00};
                        mem_wdata_q <= wdata_q >> al_shamt;
                        mem_be_q    <= al_be;
                    end else begin
                        state_q      <= RESP;
                        mem_valid_q  <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        mem_be_q     <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? '0 : rdata_d;
                    end
                end
                ACC1: begin
                    if (!we_q) hi_q <= mem_rdata;
                    state_q      <= RESP;
                    mem_valid_q  <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    mem_be_q     <= '0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? '0 : rdata_d;
                end
                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_valid       = mem_valid_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-enabled word memory, expected transactions
// and responses queued per request and compared against what the DUT produced.
module tb_load_store_unit;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mtx_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic        mem_clr = 1'b1;

    mtx_t  exp_mem[$];
    mtx_t  obs_mem[$];
    resp_t exp_resp[$];
    resp_t obs_resp[$];

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_valid       (mem_valid),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-addressed memory: combinational read, byte-lane writes on the edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_valid && mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    function automatic mtx_t mk_tx(input logic we, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] be);
        mtx_t m;
        m.we = we; m.addr = a; m.wdata = d; m.be = be;
        return m;
    endfunction

    function automatic resp_t mk_resp(input logic [31:0] d, input logic err, input logic [7:0] lat);
        resp_t r;
        r.rdata = d; r.err = err; r.lat = lat;
        return r;
    endfunction

    // Drives one request from an idle cycle, records every memory transaction and
    // the response (lat counts cycles after the accept edge; 0 if no response
    // arrives within the window).
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        resp_t r;
        int unsigned c;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r = mk_resp('0, 1'b0, 8'd0);
        c = 1;
        while (c <= 10) begin
            if (mem_valid) obs_mem.push_back(mk_tx(mem_we, mem_addr, mem_wdata, mem_byte_enable));
            if (resp_valid) begin
                r = mk_resp(resp_rdata, resp_err, 8'(c));
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        obs_resp.push_back(r);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_resp: got ready=%0b valid=%0b err=%0b rdata=%08h, want 1 0 0 00000000",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        n_tests++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got valid=%0b we=%0b addr=%08h wdata=%08h be=%04b, want all 0",
                     mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable);
        end
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        mtx_t em, om;
        resp_t er, orr;
        exp_mem.push_back(mk_tx(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111));
        exp_resp.push_back(mk_resp(32'h0, 1'b0, 8'd2));
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        while (exp_mem.size() > 0) begin
            em = exp_mem.pop_front(); n_tests++;
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (om !== em) begin
                n_fail++;
                $display("FAIL sw_mem: got we=%0b addr=%08h wdata=%08h be=%04b, want we=%0b addr=%08h wdata=%08h be=%04b",
                         om.we, om.addr, om.wdata, om.be, em.we, em.addr, em.wdata, em.be);
            end
        end
        n_tests++;
        if (obs_mem.size() != 0) begin
            n_fail++; $display("FAIL sw_extra_mem: got %0d extra txns, want 0", obs_mem.size()); obs_mem.delete();
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL sw_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
    endtask

    task automatic test_load_extend();
        mtx_t em, om;
        resp_t er, orr;
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b1000));
        exp_resp.push_back(mk_resp(32'hFFFFFFDE, 1'b0, 8'd2));
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b1000));
        exp_resp.push_back(mk_resp(32'h000000DE, 1'b0, 8'd2));
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b1100));
        exp_resp.push_back(mk_resp(32'hFFFFDEAD, 1'b0, 8'd2));
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        while (exp_mem.size() > 0) begin
            em = exp_mem.pop_front(); n_tests++;
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (om !== em) begin
                n_fail++;
                $display("FAIL load_mem: got we=%0b addr=%08h wdata=%08h be=%04b, want we=%0b addr=%08h wdata=%08h be=%04b",
                         om.we, om.addr, om.wdata, om.be, em.we, em.addr, em.wdata, em.be);
            end
        end
        n_tests++;
        if (obs_mem.size() != 0) begin
            n_fail++; $display("FAIL load_extra_mem: got %0d extra txns, want 0", obs_mem.size()); obs_mem.delete();
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL load_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
    endtask

    task automatic test_store_half();
        mtx_t em, om;
        resp_t er, orr;
        exp_mem.push_back(mk_tx(1'b1, 32'h100, 32'h00CAFE00, 4'b0110));
        exp_resp.push_back(mk_resp(32'h0, 1'b0, 8'd2));
        issue(1'b1, 3'b001, 32'h101, 32'h0000CAFE);
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b1111));
        exp_resp.push_back(mk_resp(32'hDECAFEEF, 1'b0, 8'd2));
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        while (exp_mem.size() > 0) begin
            em = exp_mem.pop_front(); n_tests++;
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (om !== em) begin
                n_fail++;
                $display("FAIL sh_mem: got we=%0b addr=%08h wdata=%08h be=%04b, want we=%0b addr=%08h wdata=%08h be=%04b",
                         om.we, om.addr, om.wdata, om.be, em.we, em.addr, em.wdata, em.be);
            end
        end
        n_tests++;
        if (obs_mem.size() != 0) begin
            n_fail++; $display("FAIL sh_extra_mem: got %0d extra txns, want 0", obs_mem.size()); obs_mem.delete();
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL sh_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
    endtask

    task automatic test_split();
        mtx_t em, om;
        resp_t er, orr;
        exp_mem.push_back(mk_tx(1'b1, 32'h0FC, 32'h33440000, 4'b1100));
        exp_mem.push_back(mk_tx(1'b1, 32'h100, 32'h00001122, 4'b0011));
        exp_resp.push_back(mk_resp(32'h0, 1'b0, 8'd3));
        issue(1'b1, 3'b010, 32'h0FE, 32'h11223344);
        exp_mem.push_back(mk_tx(1'b0, 32'h0FC, 32'h0, 4'b1100));
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b0011));
        exp_resp.push_back(mk_resp(32'h11223344, 1'b0, 8'd3));
        issue(1'b0, 3'b010, 32'h0FE, 32'h0);
        // Word 0x100 now holds DECA1122: upper half from the SH, lower from the split SW.
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b1111));
        exp_resp.push_back(mk_resp(32'hDECA1122, 1'b0, 8'd2));
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        while (exp_mem.size() > 0) begin
            em = exp_mem.pop_front(); n_tests++;
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (om !== em) begin
                n_fail++;
                $display("FAIL split_mem: got we=%0b addr=%08h wdata=%08h be=%04b, want we=%0b addr=%08h wdata=%08h be=%04b",
                         om.we, om.addr, om.wdata, om.be, em.we, em.addr, em.wdata, em.be);
            end
        end
        n_tests++;
        if (obs_mem.size() != 0) begin
            n_fail++; $display("FAIL split_extra_mem: got %0d extra txns, want 0", obs_mem.size()); obs_mem.delete();
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL split_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
    endtask

    task automatic test_illegal();
        resp_t er, orr;
        exp_resp.push_back(mk_resp(32'h0, 1'b1, 8'd1));
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        exp_resp.push_back(mk_resp(32'h0, 1'b1, 8'd1));
        issue(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
        exp_resp.push_back(mk_resp(32'h0, 1'b1, 8'd1));
        issue(1'b0, 3'b111, 32'h0FE, 32'h0);
        n_tests++;
        if (obs_mem.size() != 0) begin
            n_fail++; $display("FAIL illegal_mem: got %0d mem txns, want 0", obs_mem.size()); obs_mem.delete();
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL illegal_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
        // The rejected store must not have touched memory.
        n_tests++;
        if (mem[8'h40] !== 32'hDECA1122) begin
            n_fail++; $display("FAIL illegal_nowrite: got word 0x100=%08h, want DECA1122", mem[8'h40]);
        end
    endtask

    task automatic test_wrap();
        mtx_t em, om;
        resp_t er, orr;
        exp_mem.push_back(mk_tx(1'b1, 32'hFFFFFFFC, 32'h5A000000, 4'b1000));
        exp_mem.push_back(mk_tx(1'b1, 32'h00000000, 32'h000000A5, 4'b0001));
        exp_resp.push_back(mk_resp(32'h0, 1'b0, 8'd3));
        issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000A55A);
        exp_mem.push_back(mk_tx(1'b0, 32'hFFFFFFFC, 32'h0, 4'b1000));
        exp_mem.push_back(mk_tx(1'b0, 32'h00000000, 32'h0, 4'b0001));
        exp_resp.push_back(mk_resp(32'h0000A55A, 1'b0, 8'd3));
        issue(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0);
        exp_mem.push_back(mk_tx(1'b0, 32'hFFFFFFFC, 32'h0, 4'b1100));
        exp_mem.push_back(mk_tx(1'b0, 32'h00000000, 32'h0, 4'b0011));
        exp_resp.push_back(mk_resp(32'h00A55A00, 1'b0, 8'd3));
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        while (exp_mem.size() > 0) begin
            em = exp_mem.pop_front(); n_tests++;
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (om !== em) begin
                n_fail++;
                $display("FAIL wrap_mem: got we=%0b addr=%08h wdata=%08h be=%04b, want we=%0b addr=%08h wdata=%08h be=%04b",
                         om.we, om.addr, om.wdata, om.be, em.we, em.addr, em.wdata, em.be);
            end
        end
        n_tests++;
        if (obs_mem.size() != 0) begin
            n_fail++; $display("FAIL wrap_extra_mem: got %0d extra txns, want 0", obs_mem.size()); obs_mem.delete();
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL wrap_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
    endtask

    // req_valid held high: aligned LW accepted every 3 cycles, split every 4.
    task automatic test_back_to_back(input logic [31:0] addr, input logic [31:0] want,
                                     input int win, input int want_resp, input int want_mem);
        int n_resp, n_mem, n_rdy, bad;
        n_resp = 0; n_mem = 0; n_rdy = 0; bad = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = addr; req_wdata = '0;
        @(posedge clk); #1;
        for (int c = 1; c <= win; c++) begin
            if (resp_valid) begin
                n_resp++;
                if (resp_rdata !== want) bad++;
            end
            if (mem_valid) n_mem++;
            if (req_ready) n_rdy++;
            if (c == win) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        n_tests++;
        if (n_resp != want_resp) begin
            n_fail++; $display("FAIL b2b_resp_count @%08h: got %0d, want %0d", addr, n_resp, want_resp);
        end
        n_tests++;
        if (n_mem != want_mem) begin
            n_fail++; $display("FAIL b2b_mem_cycles @%08h: got %0d, want %0d", addr, n_mem, want_mem);
        end
        n_tests++;
        if (n_rdy != want_resp) begin
            n_fail++; $display("FAIL b2b_ready_cycles @%08h: got %0d, want %0d", addr, n_rdy, want_resp);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL b2b_rdata @%08h: got %0d wrong responses, want 0 (value %08h)", addr, bad, want);
        end
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_drain @%08h: got valid=%0b ready=%0b, want 0 1", addr, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_midop();
        int stray;
        mtx_t em, om;
        resp_t er, orr;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0FE; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL midop_acc1: got valid=%0b addr=%08h, want 1 00000100", mem_valid, mem_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if ({resp_valid, req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable} !==
            {1'b0, 1'b1, 70'h0}) begin
            n_fail++;
            $display("FAIL midop_reset: got resp_valid=%0b ready=%0b mem_valid=%0b we=%0b addr=%08h wdata=%08h be=%04b, want 0 1 and mem all 0",
                     resp_valid, req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable);
        end
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid || mem_valid) stray++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++; $display("FAIL midop_stray: got %0d active cycles after reset, want 0", stray);
        end
        exp_mem.push_back(mk_tx(1'b0, 32'h100, 32'h0, 4'b1111));
        exp_resp.push_back(mk_resp(32'hDECA1122, 1'b0, 8'd2));
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        while (exp_mem.size() > 0) begin
            em = exp_mem.pop_front(); n_tests++;
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (om !== em) begin
                n_fail++;
                $display("FAIL midop_after_mem: got we=%0b addr=%08h wdata=%08h be=%04b, want we=%0b addr=%08h wdata=%08h be=%04b",
                         om.we, om.addr, om.wdata, om.be, em.we, em.addr, em.wdata, em.be);
            end
        end
        while (exp_resp.size() > 0) begin
            er = exp_resp.pop_front(); n_tests++;
            orr = (obs_resp.size() > 0) ? obs_resp.pop_front() : '0;
            if (orr !== er) begin
                n_fail++;
                $display("FAIL midop_after_resp: got rdata=%08h err=%0b lat=%0d, want rdata=%08h err=%0b lat=%0d",
                         orr.rdata, orr.err, orr.lat, er.rdata, er.err, er.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_extend();
        test_store_half();
        test_split();
        test_illegal();
        test_wrap();
        test_back_to_back(32'h100, 32'hDECA1122, 9, 3, 3);
        test_back_to_back(32'h0FE, 32'h11223344, 8, 2, 4);
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
